// File: rtl/writeback_arbiter_pkg.sv
// Shared types for the write-back arbiter: result bundles,
// source indices and the dispatcher write-port layout.
package writeback_arbiter_pkg;

    localparam int WB_SRC_ALU     = 0;
    localparam int WB_SRC_LSU     = 1;
    localparam int NUM_WB_SOURCES = 2;

    typedef enum logic {
        SRC_ALU = 1'(WB_SRC_ALU),
        SRC_LSU = 1'(WB_SRC_LSU)
    } wb_src_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_result_t;

    typedef struct packed {
        logic        wr_en;
        logic [4:0]  rd;
        logic [31:0] wr_data;
    } wb_dispatcher_inf_t;

    // x0 writes still retire (scoreboard must clear) but carry zero data
    function automatic wb_dispatcher_inf_t wb_make_write(
        input wb_result_t r
    );
        wb_dispatcher_inf_t w;
        w.wr_en   = 1'b1;
        w.rd      = r.rd;
        w.wr_data = (r.rd == 5'd0) ? 32'd0 : r.data;
        return w;
    endfunction

    function automatic wb_src_e wb_other_src(input wb_src_e s);
        return (s == SRC_ALU) ? SRC_LSU : SRC_ALU;
    endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Small per-source result queue. Push and pop may
// happen in the same cycle; pointers wrap naturally.
module wb_result_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        pop,
    input  wb_result_t                  din,
    output wb_result_t                  dout,
    output logic                        empty,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int PW = $clog2(FIFO_DEPTH);

    wb_result_t    mem_q [FIFO_DEPTH];
    wb_result_t    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    logic [PW:0]   count_q;
    logic [PW:0]   count_d;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Queue state registers, emptied on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == (PW+1)'(FIFO_DEPTH));
    assign count = count_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and LSU results into one registered
// register-file write per cycle, queueing collisions.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int LSU_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_wb_valid,
    output logic        alu_wb_ready,
    input  logic [4:0]  alu_wb_rd,
    input  logic [31:0] alu_wb_data,
    input  logic        lsu_wb_valid,
    output logic        lsu_wb_ready,
    input  logic [4:0]  lsu_wb_rd,
    input  logic [31:0] lsu_wb_data,
    output logic [37:0] wb_dispatcher_inf,
    output logic        wb_pending
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic               ready_en_q;
    logic               ready_en_d;
    wb_src_e            rr_ptr_q;
    wb_src_e            rr_ptr_d;
    wb_dispatcher_inf_t wb_q;
    wb_dispatcher_inf_t wb_d;

    wb_result_t         alu_in;
    wb_result_t         lsu_in;
    wb_result_t         alu_head;
    wb_result_t         lsu_head;
    wb_result_t         alu_cand;
    wb_result_t         lsu_cand;

    logic               alu_empty;
    logic               alu_full;
    logic               lsu_empty;
    logic               lsu_full;
    logic [CW-1:0]      alu_count;
    logic [CW-1:0]      lsu_count;

    logic               alu_acc;
    logic               lsu_acc;
    logic               alu_cand_v;
    logic               lsu_cand_v;
    logic               contested;
    logic               grant_alu;
    logic               grant_lsu;
    logic               alu_push;
    logic               alu_pop;
    logic               lsu_push;
    logic               lsu_pop;

    assign alu_in = '{rd: alu_wb_rd, data: alu_wb_data};
    assign lsu_in = '{rd: lsu_wb_rd, data: lsu_wb_data};

    // Readys come only from registered state; held low
    // until the first edge after reset release
    assign alu_wb_ready = ready_en_q & ~alu_full;
    assign lsu_wb_ready = ready_en_q & ~lsu_full;

    // Candidate per source: queue head, else live bypass
    always_comb begin
        alu_acc    = alu_wb_valid & alu_wb_ready;
        lsu_acc    = lsu_wb_valid & lsu_wb_ready;
        alu_cand_v = ~alu_empty | alu_acc;
        lsu_cand_v = ~lsu_empty | lsu_acc;
        alu_cand   = alu_empty ? alu_in : alu_head;
        lsu_cand   = lsu_empty ? lsu_in : lsu_head;
        contested  = alu_cand_v & lsu_cand_v;
    end

    // Pick one winner; ties by fixed priority or rr_ptr
    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        unique case (1'b1)
            contested: begin
                if (LSU_PRIORITY != 0) begin
                    grant_lsu = 1'b1;
                end else if (rr_ptr_q == SRC_LSU) begin
                    grant_lsu = 1'b1;
                end else begin
                    grant_alu = 1'b1;
                end
            end
            alu_cand_v & ~lsu_cand_v: grant_alu = 1'b1;
            lsu_cand_v & ~alu_cand_v: grant_lsu = 1'b1;
            default: ;
        endcase
    end

    // Queue control: winning head pops, losing input pushes
    always_comb begin
        alu_pop  = grant_alu & ~alu_empty;
        lsu_pop  = grant_lsu & ~lsu_empty;
        alu_push = alu_acc & ~(grant_alu & alu_empty);
        lsu_push = lsu_acc & ~(grant_lsu & lsu_empty);
    end

    // Next-state for pointer, ready enable and write port
    always_comb begin
        ready_en_d = 1'b1;
        rr_ptr_d   = rr_ptr_q;
        wb_d       = wb_q;
        wb_d.wr_en = 1'b0;
        if (contested) begin
            rr_ptr_d = wb_other_src(rr_ptr_q);
        end
        if (grant_lsu) begin
            wb_d = wb_make_write(lsu_cand);
        end else if (grant_alu) begin
            wb_d = wb_make_write(alu_cand);
        end
    end

    // Arbiter state; reset discards the pending write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
            rr_ptr_q   <= SRC_ALU;
            wb_q       <= '0;
        end else begin
            ready_en_q <= ready_en_d;
            rr_ptr_q   <= rr_ptr_d;
            wb_q       <= wb_d;
        end
    end

    wb_result_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_alu_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (alu_push),
        .pop   (alu_pop),
        .din   (alu_in),
        .dout  (alu_head),
        .empty (alu_empty),
        .full  (alu_full),
        .count (alu_count)
    );

    wb_result_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_lsu_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (lsu_push),
        .pop   (lsu_pop),
        .din   (lsu_in),
        .dout  (lsu_head),
        .empty (lsu_empty),
        .full  (lsu_full),
        .count (lsu_count)
    );

    assign wb_dispatcher_inf = wb_q;
    assign wb_pending = (alu_count != '0) | (lsu_count != '0)
                      | wb_q.wr_en;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: round-robin and LSU-priority
// instances checked against a queue-level model.
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        av = 1'b0;
    logic        lv = 1'b0;
    logic [4:0]  ard = '0;
    logic [4:0]  lrd = '0;
    logic [31:0] adat = '0;
    logic [31:0] ldat = '0;

    logic        ardy0, lrdy0, pend0;
    logic        ardy1, lrdy1, pend1;
    logic [37:0] wb0, wb1;

    always #5 clk = ~clk;

    writeback_arbiter #(.FIFO_DEPTH(DEPTH), .LSU_PRIORITY(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_wb_valid(av), .alu_wb_ready(ardy0),
        .alu_wb_rd(ard), .alu_wb_data(adat),
        .lsu_wb_valid(lv), .lsu_wb_ready(lrdy0),
        .lsu_wb_rd(lrd), .lsu_wb_data(ldat),
        .wb_dispatcher_inf(wb0), .wb_pending(pend0)
    );

    writeback_arbiter #(.FIFO_DEPTH(DEPTH), .LSU_PRIORITY(1)) dut_p (
        .clk(clk), .rst_n(rst_n),
        .alu_wb_valid(av), .alu_wb_ready(ardy1),
        .alu_wb_rd(ard), .alu_wb_data(adat),
        .lsu_wb_valid(lv), .lsu_wb_ready(lrdy1),
        .lsu_wb_rd(lrd), .lsu_wb_data(ldat),
        .wb_dispatcher_inf(wb1), .wb_pending(pend1)
    );

    int checks = 0;
    int failures = 0;
    bit sel = 1'b0;

    // producer scripts: {idle, rd, data}
    logic [37:0] fa[$];
    logic [37:0] fl[$];

    // model: results accepted but not yet written
    logic [36:0] qa[$];
    logic [36:0] ql[$];
    bit          rr;
    bit          exp_en;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    bit          exp_ardy, exp_lrdy, exp_pend;

    function automatic logic [40:0] obs();
        if (sel) return {wb1, ardy1, lrdy1, pend1};
        return {wb0, ardy0, lrdy0, pend0};
    endfunction

    function automatic logic [40:0] expv();
        return {exp_en, exp_rd, exp_data, exp_ardy, exp_lrdy, exp_pend};
    endfunction

    function automatic bit busy();
        return fa.size() > 0 || fl.size() > 0 || qa.size() > 0
            || ql.size() > 0 || exp_en;
    endfunction

    task automatic model_reset();
        qa.delete(); ql.delete(); fa.delete(); fl.delete();
        rr = 1'b0;
        exp_en = 1'b0; exp_rd = '0; exp_data = '0;
        exp_ardy = 1'b0; exp_lrdy = 1'b0; exp_pend = 1'b0;
        av = 1'b0; lv = 1'b0;
    endtask

    task automatic step();
        logic [36:0] it;
        bit a_acc, l_acc, ca, cl, win_l;
        av = 1'b0; lv = 1'b0;
        if (fa.size() > 0 && !fa[0][37]) begin
            av = 1'b1; {ard, adat} = fa[0][36:0];
        end
        if (fl.size() > 0 && !fl[0][37]) begin
            lv = 1'b1; {lrd, ldat} = fl[0][36:0];
        end
        a_acc = av && exp_ardy;
        l_acc = lv && exp_lrdy;
        if (a_acc) qa.push_back({ard, adat});
        if (l_acc) ql.push_back({lrd, ldat});
        if (fa.size() > 0 && (fa[0][37] || a_acc)) fa.delete(0);
        if (fl.size() > 0 && (fl[0][37] || l_acc)) fl.delete(0);
        ca = qa.size() > 0;
        cl = ql.size() > 0;
        if (ca && cl) begin
            win_l = sel ? 1'b1 : rr;
            rr = ~rr;
        end else begin
            win_l = cl;
        end
        exp_en = ca || cl;
        if (exp_en) begin
            if (win_l) begin it = ql[0]; ql.delete(0); end
            else begin it = qa[0]; qa.delete(0); end
            exp_rd = it[36:32];
            exp_data = (it[36:32] == 5'd0) ? 32'd0 : it[31:0];
        end
        exp_ardy = qa.size() < DEPTH;
        exp_lrdy = ql.size() < DEPTH;
        exp_pend = qa.size() > 0 || ql.size() > 0 || exp_en;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        checks++;
        if (obs() !== 41'd0) begin
            failures++;
            $display("FAIL reset_low got=%h exp=0", obs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (obs() !== {38'd0, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h",
                     obs(), {38'd0, 3'b110});
        end
    endtask

    task automatic test_single();
        fa.push_back({1'b0, 5'd5, 32'hDEADBEEF});
        step();
        checks++;
        if (obs()[40:3] !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL single_t1 got=%h exp=%h",
                     obs()[40:3], {1'b1, 5'd5, 32'hDEADBEEF});
        end
        step();
        checks++;
        if (obs()[40] !== 1'b0 || obs() !== expv()) begin
            failures++;
            $display("FAIL single_t2 got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_contention();
        fa.push_back({1'b0, 5'd1, 32'h11});
        fl.push_back({1'b0, 5'd2, 32'h22});
        step();
        checks++;
        if (obs()[40:3] !== {1'b1, 5'd1, 32'h11} || obs()[1] !== 1'b1) begin
            failures++;
            $display("FAIL contend_t1 got=%h exp=%h lrdy=1",
                     obs()[40:3], {1'b1, 5'd1, 32'h11});
        end
        step();
        checks++;
        if (obs()[40:3] !== {1'b1, 5'd2, 32'h22} || obs()[1] !== 1'b1) begin
            failures++;
            $display("FAIL contend_t2 got=%h exp=%h lrdy=1",
                     obs()[40:3], {1'b1, 5'd2, 32'h22});
        end
        fa.push_back({1'b0, 5'd3, 32'h33});
        fl.push_back({1'b0, 5'd4, 32'h44});
        step();
        checks++;
        if (obs()[40:3] !== {1'b1, 5'd4, 32'h44}) begin
            failures++;
            $display("FAIL contend_rr got=%h exp=%h",
                     obs()[40:3], {1'b1, 5'd4, 32'h44});
        end
        for (int c = 0; c < 10 && busy(); c++) begin
            step();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL contend_drain got=%h exp=%h", obs(), expv());
            end
        end
    endtask

    task automatic test_back_to_back();
        int nw, last;
        nw = 0; last = 0;
        for (int i = 0; i < 8; i++) begin
            fa.push_back({1'b0, 5'(i + 1), $urandom()});
            fl.push_back({1'b0, 5'(i + 9), $urandom()});
        end
        for (int c = 1; c <= 40 && busy(); c++) begin
            step();
            if (obs()[40]) begin nw++; last = c; end
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL b2b_cycle%0d got=%h exp=%h", c, obs(), expv());
            end
        end
        checks++;
        if (nw !== 16 || last !== 16 || busy()) begin
            failures++;
            $display("FAIL b2b_rate writes=%0d last=%0d exp 16/16", nw, last);
        end
    endtask

    task automatic test_x0();
        fl.push_back({1'b0, 5'd0, 32'h1234});
        step();
        checks++;
        if (obs()[40:3] !== {1'b1, 5'd0, 32'h0}) begin
            failures++;
            $display("FAIL x0_zero got=%h exp=%h",
                     obs()[40:3], {1'b1, 5'd0, 32'h0});
        end
        step();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            fa.push_back({1'b0, 5'(i + 20), $urandom()});
            fl.push_back({1'b0, 5'(i + 24), $urandom()});
        end
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 41'd0) begin
            failures++;
            $display("FAIL reset_mid got=%h exp=0", obs());
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        fa.push_back({1'b0, 5'd7, 32'h77});
        for (int c = 0; c < 10 && busy(); c++) begin
            step();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL reset_new got=%h exp=%h", obs(), expv());
            end
        end
        checks++;
        if (exp_rd !== 5'd7 || obs()[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_after rd=%0d pend=%b exp rd=7 pend=0",
                     obs()[39:35], obs()[0]);
        end
    endtask

    task automatic test_random();
        int nitems, nw;
        nitems = 0; nw = 0;
        for (int c = 0; c < 400; c++) begin
            if (fa.size() < 3) begin
                fa.push_back({($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
                              5'($urandom_range(0, 31)), $urandom()});
                if (!fa[fa.size() - 1][37]) nitems++;
            end
            if (fl.size() < 3) begin
                fl.push_back({($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0,
                              5'($urandom_range(0, 31)), $urandom()});
                if (!fl[fl.size() - 1][37]) nitems++;
            end
            step();
            if (obs()[40]) nw++;
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL random_c%0d got=%h exp=%h", c, obs(), expv());
            end
        end
        for (int c = 0; c < 40 && busy(); c++) begin
            step();
            if (obs()[40]) nw++;
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL random_drain got=%h exp=%h", obs(), expv());
            end
        end
        checks++;
        if (nw !== nitems || busy()) begin
            failures++;
            $display("FAIL random_count writes=%0d exp=%0d", nw, nitems);
        end
    endtask

    task automatic test_lsu_priority();
        logic [4:0] got[$];
        logic [4:0] want[$];
        bit saw_block;
        saw_block = 1'b0;
        sel = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            fa.push_back({1'b0, 5'(i + 1), $urandom()});
            fl.push_back({1'b0, 5'(i + 17), $urandom()});
        end
        for (int i = 0; i < 6; i++) want.push_back(5'(i + 17));
        for (int i = 0; i < 6; i++) want.push_back(5'(i + 1));
        for (int c = 0; c < 30 && busy(); c++) begin
            step();
            if (obs()[40]) got.push_back(obs()[39:35]);
            if (!obs()[2]) saw_block = 1'b1;
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL prio_cycle%0d got=%h exp=%h", c, obs(), expv());
            end
        end
        checks++;
        if (got !== want || !saw_block) begin
            failures++;
            $display("FAIL prio_order n=%0d block=%b exp n=12 block=1",
                     got.size(), saw_block);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_x0();
        test_reset_mid();
        test_random();
        test_lsu_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
